// File: rtl/id_hazard_stage.sv
// ID->EX pipeline register with load-use hazard scoreboard,
// EX back-pressure, jump nullify and a saturating stall counter.
module id_hazard_stage #(
  parameter int XLEN     = 32,
  parameter int RBITS    = 5,
  parameter int CTRL_W   = 16,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              id_valid,
  input  logic [RBITS-1:0]  id_rs1,
  input  logic [RBITS-1:0]  id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [RBITS-1:0]  id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_rd_we,
  output logic              ex_is_load,
  output logic [RBITS-1:0]  ex_rs1,
  output logic [RBITS-1:0]  ex_rs2,
  output logic [RBITS-1:0]  ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CNT_W-1:0]  hazard_stalls
);

  typedef struct packed {
    logic              valid;
    logic              rd_we;
    logic              is_load;
    logic [RBITS-1:0]  rs1;
    logic [RBITS-1:0]  rs2;
    logic [RBITS-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
  } ex_t;

  ex_t              id_b;
  ex_t              ex_q;
  logic             hazard;
  logic             sb_shift;
  logic             sb_in_v;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    id_b         = '0;
    id_b.valid   = id_valid;
    id_b.rd_we   = id_rd_we;
    id_b.is_load = id_is_load;
    id_b.rs1     = id_rs1;
    id_b.rs2     = id_rs2;
    id_b.rd      = id_rd;
    id_b.ctrl    = id_ctrl;
    id_b.imm     = id_imm;
    id_b.pc      = id_pc;
  end

  // Scoreboard advances on every cycle EX is not frozen.
  assign sb_shift = flush || ex_ready;
  assign sb_in_v  = !flush && !hazard && id_valid
                 && id_is_load && id_rd_we
                 && (id_rd != '0);

  generate
    if (LOAD_LAT == 0) begin : g_nosb
      assign hazard = 1'b0;
    end else begin : g_sb
      logic [LOAD_LAT-1:0] sb_v;
      logic [RBITS-1:0]    sb_rd [LOAD_LAT];
      logic [LOAD_LAT-1:0] match;

      always_comb begin
        match = '0;
        for (int k = 0; k < LOAD_LAT; k++) begin
          match[k] = sb_v[k]
                  && (sb_rd[k] != '0)
                  && ((id_rs1_used && (id_rs1 == sb_rd[k]))
                   || (id_rs2_used && (id_rs2 == sb_rd[k])));
        end
      end

      assign hazard = id_valid && (|match);

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sb_v <= '0;
          for (int k = 0; k < LOAD_LAT; k++) begin
            sb_rd[k] <= '0;
          end
        end else if (sb_shift) begin
          for (int k = LOAD_LAT - 1; k > 0; k--) begin
            sb_v[k]  <= sb_v[k-1];
            sb_rd[k] <= sb_rd[k-1];
          end
          sb_v[0]  <= sb_in_v;
          sb_rd[0] <= id_rd;
        end
      end
    end
  endgenerate

  assign id_stall = !flush && (hazard || !ex_ready);

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      ex_q <= '0;
    end else if (ex_ready) begin
      ex_q <= hazard ? '0 : id_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!flush && ex_ready && hazard
                 && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_rd_we      = ex_q.rd_we;
  assign ex_is_load    = ex_q.is_load;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_ctrl       = ex_q.ctrl;
  assign ex_imm        = ex_q.imm;
  assign ex_pc         = ex_q.pc;
  assign hazard_stalls = cnt_q;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Bench for id_hazard_stage: five instances (various LOAD_LAT / CNT_W)
// share stimulus; a queue holds instructions expected to reach EX.
module tb_id_hazard_stage;

  localparam int N = 5;
  localparam int LATS [N] = '{1, 2, 3, 1, 0};
  localparam int CWS  [N] = '{16, 16, 16, 2, 16};

  typedef struct packed {
    logic        ld;
    logic        we;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
  } ins_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_load;
  logic [15:0] id_ctrl;
  logic [31:0] id_imm;
  logic [31:0] id_pc;

  logic        st_a   [N];
  logic        v_a    [N];
  logic        we_a   [N];
  logic        ld_a   [N];
  logic [4:0]  rs1_a  [N];
  logic [4:0]  rs2_a  [N];
  logic [4:0]  rd_a   [N];
  logic [15:0] ctrl_a [N];
  logic [31:0] imm_a  [N];
  logic [31:0] pc_a   [N];
  logic [15:0] cnt_a  [N];

  genvar g;
  for (g = 0; g < N; g++) begin : g_dut
    localparam int CW = CWS[g];
    logic [CW-1:0] c;
    id_hazard_stage #(
      .XLEN(32), .RBITS(5), .CTRL_W(16),
      .LOAD_LAT(LATS[g]), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .flush(flush), .ex_ready(ex_ready),
      .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_rd_we(id_rd_we),
      .id_is_load(id_is_load),
      .id_ctrl(id_ctrl), .id_imm(id_imm),
      .id_pc(id_pc),
      .id_stall(st_a[g]),
      .ex_valid(v_a[g]),
      .ex_rd_we(we_a[g]),
      .ex_is_load(ld_a[g]),
      .ex_rs1(rs1_a[g]), .ex_rs2(rs2_a[g]),
      .ex_rd(rd_a[g]),
      .ex_ctrl(ctrl_a[g]),
      .ex_imm(imm_a[g]), .ex_pc(pc_a[g]),
      .hazard_stalls(c)
    );
    assign cnt_a[g] = 16'(c);
  end

  always #5 clk = ~clk;

  int          sel = 0;
  logic        o_stall, o_valid, o_we, o_ld;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [15:0] o_ctrl, o_cnt;
  logic [31:0] o_imm, o_pc;

  always_comb begin
    o_stall = st_a[sel];
    o_valid = v_a[sel];
    o_we    = we_a[sel];
    o_ld    = ld_a[sel];
    o_rs1   = rs1_a[sel];
    o_rs2   = rs2_a[sel];
    o_rd    = rd_a[sel];
    o_ctrl  = ctrl_a[sel];
    o_imm   = imm_a[sel];
    o_pc    = pc_a[sel];
    o_cnt   = cnt_a[sel];
  end

  int   n_chk  = 0;
  int   n_fail = 0;
  ins_t exp_q [$];

  function automatic ins_t mk(input logic ld, input logic we,
                              input int rd, input int rs1,
                              input logic u1, input int rs2,
                              input logic u2, input int pc);
    ins_t i;
    i.ld  = ld;
    i.we  = we;
    i.u1  = u1;
    i.u2  = u2;
    i.rd  = 5'(rd);
    i.rs1 = 5'(rs1);
    i.rs2 = 5'(rs2);
    i.pc  = 32'(pc);
    return i;
  endfunction

  task automatic idle();
    id_valid    = 1'b0;
    id_is_load  = 1'b0;
    id_rd_we    = 1'b0;
    id_rd       = '0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_ctrl     = '0;
    id_imm      = '0;
    id_pc       = '0;
  endtask

  task automatic drive(input ins_t i);
    id_valid    = 1'b1;
    id_is_load  = i.ld;
    id_rd_we    = i.we;
    id_rd       = i.rd;
    id_rs1      = i.rs1;
    id_rs2      = i.rs2;
    id_rs1_used = i.u1;
    id_rs2_used = i.u2;
    id_pc       = i.pc;
    id_imm      = ~i.pc;
    id_ctrl     = i.pc[15:0] ^ 16'h5a5a;
  endtask

  // Clock edge plus scoreboard pop for whatever EX just accepted.
  task automatic tick();
    ins_t e;
    logic [15:0] ectl;
    @(posedge clk);
    #1;
    if (o_valid && ex_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ex_unexpected: got pc %h, wanted no instruction",
                 o_pc);
      end else begin
        e = exp_q.pop_front();
        ectl = e.pc[15:0] ^ 16'h5a5a;
        if (o_pc !== e.pc || o_rd !== e.rd || o_we !== e.we ||
            o_ld !== e.ld || o_rs1 !== e.rs1 || o_rs2 !== e.rs2 ||
            o_imm !== ~e.pc || o_ctrl !== ectl) begin
          n_fail++;
          $display("FAIL ex_bundle: got pc %h rd %0d we %b ld %b imm %h ctrl %h, wanted pc %h rd %0d we %b ld %b imm %h ctrl %h",
                   o_pc, o_rd, o_we, o_ld, o_imm, o_ctrl,
                   e.pc, e.rd, e.we, e.ld, ~e.pc, ectl);
        end
      end
    end else if (!o_valid) begin
      n_chk++;
      if ({o_we, o_ld, o_rd, o_rs1, o_rs2, o_ctrl} !== '0) begin
        n_fail++;
        $display("FAIL bubble_fields: got we %b ld %b rd %0d rs1 %0d rs2 %0d ctrl %h, wanted all 0",
                 o_we, o_ld, o_rd, o_rs1, o_rs2, o_ctrl);
      end
    end
  endtask

  task automatic issue(input ins_t i, output int stalls,
                       output int bubbles);
    logic s;
    drive(i);
    exp_q.push_back(i);
    stalls  = 0;
    bubbles = 0;
    s = 1'b1;
    for (int c = 0; c < 12 && s; c++) begin
      #1;
      s = o_stall;
      if (s) stalls++;
      tick();
      if (s && !o_valid) bubbles++;
    end
    if (s) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: pc %h stalled 12 cycles, wanted acceptance",
               i.pc);
    end
    idle();
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    idle();
    tick();
    tick();
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < N; k++) begin
      sel = k;
      #1;
      n_chk++;
      if (o_valid !== 1'b0 || o_pc !== '0 || o_cnt !== '0 ||
          o_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got v %b pc %h cnt %0d stall %b, wanted 0 0 0 0",
                 k, o_valid, o_pc, o_cnt, o_stall);
      end
    end
  endtask

  task automatic test_lat1_basic();
    int st, bb;
    sel = 0;
    do_reset();
    issue(mk(1, 1, 5, 2, 1, 0, 0, 'h100), st, bb);
    n_chk++;
    if (st !== 0) begin
      n_fail++;
      $display("FAIL lat1_load: got %0d stalls, wanted 0", st);
    end
    issue(mk(0, 1, 6, 5, 1, 0, 0, 'h104), st, bb);
    n_chk++;
    if (st !== 1 || bb !== 1) begin
      n_fail++;
      $display("FAIL lat1_use: got %0d stalls %0d bubbles, wanted 1 1",
               st, bb);
    end
    n_chk++;
    if (o_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL lat1_cnt: got %0d, wanted 1", o_cnt);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lat1_drain: got %0d pending, wanted 0",
               exp_q.size());
    end
  endtask

  task automatic test_lat3();
    int st, bb, st2;
    sel = 2;
    do_reset();
    issue(mk(1, 1, 7, 0, 0, 0, 0, 'h200), st, bb);
    issue(mk(0, 1, 9, 7, 1, 0, 0, 'h204), st, bb);
    n_chk++;
    if (st !== 3 || bb !== 3 || o_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL lat3_direct: got st %0d bb %0d cnt %0d, wanted 3 3 3",
               st, bb, o_cnt);
    end
    do_reset();
    issue(mk(1, 1, 7, 0, 0, 0, 0, 'h210), st, bb);
    issue(mk(0, 1, 10, 1, 1, 0, 0, 'h214), st, bb);
    issue(mk(0, 1, 11, 7, 1, 0, 0, 'h218), st, bb);
    n_chk++;
    if (st !== 2) begin
      n_fail++;
      $display("FAIL lat3_gap1: got %0d stalls, wanted 2", st);
    end
    do_reset();
    issue(mk(1, 1, 7, 0, 0, 0, 0, 'h220), st, bb);
    issue(mk(0, 1, 10, 1, 1, 0, 0, 'h224), st, bb);
    issue(mk(0, 1, 12, 2, 1, 0, 0, 'h228), st, bb);
    issue(mk(0, 1, 11, 0, 0, 7, 1, 'h22c), st, bb);
    n_chk++;
    if (st !== 1) begin
      n_fail++;
      $display("FAIL lat3_gap2: got %0d stalls, wanted 1", st);
    end
    do_reset();
    issue(mk(1, 1, 7, 0, 0, 0, 0, 'h230), st, bb);
    issue(mk(1, 1, 8, 7, 1, 0, 0, 'h234), st, bb);
    issue(mk(0, 1, 13, 0, 0, 8, 1, 'h238), st2, bb);
    n_chk++;
    if (st !== 3 || st2 !== 3 || o_cnt !== 16'd6) begin
      n_fail++;
      $display("FAIL lat3_chain: got %0d/%0d stalls cnt %0d, wanted 3/3 cnt 6",
               st, st2, o_cnt);
    end
  endtask

  task automatic test_false_hazard();
    int st, bb, tot;
    sel = 0;
    do_reset();
    tot = 0;
    issue(mk(1, 1, 0, 0, 0, 0, 0, 'h300), st, bb);
    issue(mk(0, 1, 6, 0, 1, 0, 1, 'h304), st, bb);
    n_chk++;
    if (st !== 0) begin
      n_fail++;
      $display("FAIL false_r0: got %0d stalls, wanted 0", st);
    end
    issue(mk(1, 1, 4, 0, 0, 0, 0, 'h308), st, bb);
    issue(mk(0, 1, 6, 3, 1, 4, 0, 'h30c), st, bb);
    n_chk++;
    if (st !== 0) begin
      n_fail++;
      $display("FAIL false_unused: got %0d stalls, wanted 0", st);
    end
    issue(mk(0, 1, 4, 0, 0, 0, 0, 'h310), st, bb);
    issue(mk(0, 1, 6, 4, 1, 4, 1, 'h314), st, bb);
    n_chk++;
    if (st !== 0 || o_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL false_nonload: got st %0d cnt %0d, wanted 0 0",
               st, o_cnt);
    end
  endtask

  task automatic test_flush();
    int st, bb;
    sel = 1;
    do_reset();
    issue(mk(1, 1, 3, 0, 0, 0, 0, 'h400), st, bb);
    drive(mk(0, 1, 11, 3, 1, 0, 0, 'h404));
    #1;
    n_chk++;
    if (o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: got stall %b, wanted 1", o_stall);
    end
    flush = 1'b1;
    #1;
    n_chk++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: got stall %b, wanted 0", o_stall);
    end
    tick();
    flush = 1'b0;
    idle();
    n_chk++;
    if (o_valid !== 1'b0 || o_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL flush_bubble: got v %b cnt %0d, wanted 0 0",
               o_valid, o_cnt);
    end
    issue(mk(0, 1, 12, 3, 1, 0, 0, 'h408), st, bb);
    n_chk++;
    if (st !== 1 || o_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL flush_after: got st %0d cnt %0d, wanted 1 1",
               st, o_cnt);
    end
    issue(mk(0, 1, 13, 0, 0, 0, 0, 'h40c), st, bb);
    ex_ready = 1'b0;
    flush = 1'b1;
    drive(mk(0, 1, 14, 0, 0, 0, 0, 'h410));
    #1;
    n_chk++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bp_stall: got %b, wanted 0", o_stall);
    end
    tick();
    n_chk++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bp_valid: got %b, wanted 0", o_valid);
    end
    flush = 1'b0;
    ex_ready = 1'b1;
    idle();
  endtask

  task automatic test_backpressure();
    int st, bb;
    ins_t dep;
    sel = 0;
    do_reset();
    issue(mk(1, 1, 9, 0, 0, 0, 0, 'h500), st, bb);
    dep = mk(0, 1, 14, 9, 1, 0, 0, 'h504);
    ex_ready = 1'b0;
    drive(dep);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++;
      if (o_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: got %b, wanted 1", c, o_stall);
      end
      tick();
      n_chk++;
      if (o_valid !== 1'b1 || o_pc !== 32'h500 || o_rd !== 5'd9 ||
          o_ld !== 1'b1 || o_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL bp_frozen[%0d]: got v %b pc %h rd %0d ld %b cnt %0d, wanted 1 500 9 1 0",
                 c, o_valid, o_pc, o_rd, o_ld, o_cnt);
      end
    end
    ex_ready = 1'b1;
    issue(dep, st, bb);
    n_chk++;
    if (st !== 1 || o_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_release: got st %0d cnt %0d, wanted 1 1",
               st, o_cnt);
    end
  endtask

  task automatic test_saturation();
    int st, bb, tot;
    sel = 3;
    do_reset();
    tot = 0;
    issue(mk(1, 1, 1, 0, 0, 0, 0, 'h600), st, bb);
    for (int k = 0; k < 5; k++) begin
      issue(mk(1, 1, 1, 1, 1, 0, 0, 'h604 + 4 * k), st, bb);
      tot += st;
    end
    n_chk++;
    if (tot !== 5 || o_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL saturate: got %0d stalls cnt %0d, wanted 5 3",
               tot, o_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    int st, bb;
    ins_t cons;
    sel = 2;
    do_reset();
    issue(mk(1, 1, 7, 0, 0, 0, 0, 'h700), st, bb);
    cons = mk(0, 1, 15, 7, 1, 0, 0, 'h704);
    drive(cons);
    #1;
    n_chk++;
    if (o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got stall %b, wanted 1", o_stall);
    end
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_chk++;
    if (o_valid !== 1'b0 || o_cnt !== 16'd0 || o_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_clear: got v %b cnt %0d rd %0d, wanted 0 0 0",
               o_valid, o_cnt, o_rd);
    end
    #1;
    n_chk++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: got stall %b, wanted 0", o_stall);
    end
    exp_q.push_back(cons);
    tick();
    idle();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_drain: got %0d pending, wanted 0",
               exp_q.size());
    end
  endtask

  task automatic test_lat0();
    int st, bb;
    sel = 4;
    do_reset();
    issue(mk(1, 1, 5, 0, 0, 0, 0, 'h800), st, bb);
    issue(mk(0, 1, 6, 5, 1, 5, 1, 'h804), st, bb);
    n_chk++;
    if (st !== 0 || o_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL lat0: got st %0d cnt %0d, wanted 0 0", st, o_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lat1_basic();
    test_lat3();
    test_false_hazard();
    test_flush();
    test_backpressure();
    test_saturation();
    test_reset_mid_stall();
    test_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
